// File: rtl/sample_uart_tx_pkg.sv
// Shared encodings and helpers for the sample-memory UART transmitter.
package sample_uart_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;
  typedef enum logic [1:0] {WORD_IDLE, WORD_EMPTY, WORD_SEND} wordState_t;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned NUM_GROUPS      = 4;

  // Lowest enabled group at or above fromIdx; 4 means none remain.
  function automatic logic [2:0] firstEnabled(input logic [3:0] disabledMask,
                                              input logic [2:0] fromIdx);
    logic [2:0] g;
    g = 3'd4;
    for (int unsigned i = NUM_GROUPS; i > 0; i--) begin
      if ((3'(i - 1) >= fromIdx) && !disabledMask[2'(i - 1)]) g = 3'(i - 1);
    end
    return g;
  endfunction

endpackage

// File: rtl/sample_uart_tx_byte.sv
// Single 8N1 byte serializer with a fixed-divider baud counter.
module uart_byte_tx
  import sample_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ld,
  input  logic [7:0] byteIn,
  output logic       tx,
  output logic       done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  uartState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [7:0]       shiftReg, shiftNext;
  logic [2:0]       bitIdx, bitNext;
  logic             txNext;
  logic             bitEnd;

  assign bitEnd = (cnt == '0);
  assign done   = (state == STOP) && bitEnd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shiftReg <= '0;
      bitIdx   <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitNext;
      tx       <= txNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = bitEnd ? cnt : cnt - CNT_W'(1);
    shiftNext = shiftReg;
    bitNext   = bitIdx;
    txNext    = tx;
    case (state)
      IDLE: txNext = 1'b1;
      START: if (bitEnd) begin
        stateNext = DATA;
        txNext    = shiftReg[0];
        cntNext   = RELOAD;
        bitNext   = '0;
      end
      DATA: if (bitEnd) begin
        cntNext = RELOAD;
        if (bitIdx == 3'(UART_DATA_BITS - 1)) begin
          stateNext = STOP;
          txNext    = 1'b1;
        end else begin
          shiftNext = shiftReg >> 1;
          txNext    = shiftReg[1];
          bitNext   = bitIdx + 3'd1;
        end
      end
      STOP: if (bitEnd) begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (ld) shiftNext = byteIn;
    // A start in the last stop cycle chains the next frame with no idle gap.
    if (start) begin
      stateNext = START;
      txNext    = 1'b0;
      cntNext   = RELOAD;
    end
  end

endmodule

// File: rtl/sample_uart_tx.sv
// Word holding register and group-skip byte sequencing over uart_byte_tx.
module sample_uart_tx
  import sample_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        send,
  input  logic [31:0] dataIn,
  input  logic [3:0]  disabledGroups,
  output logic        busy,
  output logic        tx,
  output logic        overrun
);

  wordState_t  wordState, wordNext;
  logic [31:0] wordReg;
  logic [3:0]  disReg;
  logic [2:0]  byteIdx, idxNext;
  logic [31:0] srcWord;
  logic [3:0]  srcDis;
  logic [2:0]  srcIdx, selG;
  logic [7:0]  selByte;
  logic        found, startByte, byteDone;

  assign busy = (wordState != WORD_IDLE);

  // Selection reads the live inputs on acceptance so the first start bit
  // leaves on the cycle after the strobe.
  assign srcWord = (wordState == WORD_IDLE) ? dataIn : wordReg;
  assign srcDis  = (wordState == WORD_IDLE) ? disabledGroups : disReg;
  assign srcIdx  = (wordState == WORD_IDLE) ? 3'd0 : byteIdx;
  assign selG    = firstEnabled(srcDis, srcIdx);
  assign found   = !selG[2];
  assign selByte = srcWord[{selG[1:0], 3'b000} +: 8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wordState <= WORD_IDLE;
      wordReg   <= '0;
      disReg    <= '0;
      byteIdx   <= '0;
      overrun   <= 1'b0;
    end else begin
      wordState <= wordNext;
      byteIdx   <= idxNext;
      if ((wordState == WORD_IDLE) && send) begin
        wordReg <= dataIn;
        disReg  <= disabledGroups;
      end
      if (send && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    wordNext  = wordState;
    idxNext   = byteIdx;
    startByte = 1'b0;
    case (wordState)
      WORD_IDLE: if (send) begin
        if (found) begin
          startByte = 1'b1;
          idxNext   = selG + 3'd1;
          wordNext  = WORD_SEND;
        end else begin
          idxNext  = '0;
          wordNext = WORD_EMPTY;
        end
      end
      WORD_EMPTY: wordNext = WORD_IDLE;
      WORD_SEND: if (byteDone) begin
        if (found) begin
          startByte = 1'b1;
          idxNext   = selG + 3'd1;
        end else begin
          idxNext  = '0;
          wordNext = WORD_IDLE;
        end
      end
      default: wordNext = WORD_IDLE;
    endcase
  end

  uart_byte_tx #(
    .BAUD_DIV(BAUD_DIV),
    .CNT_W   (CNT_W)
  ) byteTx (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (startByte),
    .ld     (startByte),
    .byteIn (selByte),
    .tx     (tx),
    .done   (byteDone)
  );

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench: fast-divider instance for framing/sequencing, slow one for bit timing.
module tb_sample_uart_tx;

  localparam int unsigned FAST_DIV = 4;
  localparam int unsigned SLOW_DIV = 868;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        send, sSend;
  logic [31:0] dataIn, sData;
  logic [3:0]  dis, sDis;
  logic        busy, tx, overrun;
  logic        sBusy, sTx, sOverrun;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  sample_uart_tx #(.BAUD_DIV(FAST_DIV), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .send(send), .dataIn(dataIn),
    .disabledGroups(dis), .busy(busy), .tx(tx), .overrun(overrun)
  );

  sample_uart_tx #(.BAUD_DIV(SLOW_DIV), .CNT_W(16)) dutSlow (
    .clock(clock), .reset_n(reset_n), .send(sSend), .dataIn(sData),
    .disabledGroups(sDis), .busy(sBusy), .tx(sTx), .overrun(sOverrun)
  );

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Entered one cycle after acceptance (or chained start); checks every cycle of the frame.
  task automatic checkFrame(input string tag, input logic [7:0] b, input int pulseAt);
    int  k;
    logic expBit;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < int'(FAST_DIV); c++) begin
        if (i == 0) expBit = 1'b0;
        else if (i == 9) expBit = 1'b1;
        else expBit = b[3'(i - 1)];
        send = (k == pulseAt);
        if (k == pulseAt) dataIn = 32'hFFFF_FFFF;
        checkBit($sformatf("%s tx bit%0d cyc%0d", tag, i, c), tx, expBit);
        checkBit($sformatf("%s busy bit%0d cyc%0d", tag, i, c), busy, 1'b1);
        tick;
        k++;
      end
    end
    send = 1'b0;
  endtask

  initial begin
    logic expBit;
    logic [7:0] slowByte;
    reset_n = 1'b0;
    send = 1'b0; dataIn = '0; dis = '0;
    sSend = 1'b0; sData = '0; sDis = '0;
    tick; tick;
    checkBit("reset tx", tx, 1'b1);
    checkBit("reset busy", busy, 1'b0);
    checkBit("reset overrun", overrun, 1'b0);
    checkBit("reset slow tx", sTx, 1'b1);
    checkBit("reset slow busy", sBusy, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      tick;
      checkBit("idle tx", tx, 1'b1);
      checkBit("idle busy", busy, 1'b0);
      checkBit("idle overrun", overrun, 1'b0);
    end

    // Four enabled bytes; inputs scrambled after capture.
    dataIn = 32'h4433_2211; dis = 4'b0000; send = 1'b1;
    tick;
    send = 1'b0; dataIn = 32'hDEAD_BEEF; dis = 4'b1111;
    checkFrame("w1b0", 8'h11, -1);
    checkFrame("w1b1", 8'h22, -1);
    checkFrame("w1b2", 8'h33, -1);
    checkFrame("w1b3", 8'h44, -1);
    checkBit("w1 end busy", busy, 1'b0);
    checkBit("w1 end tx", tx, 1'b1);

    // Groups 0 and 2 disabled.
    dataIn = 32'hDDCC_BBAA; dis = 4'b0101; send = 1'b1;
    tick;
    send = 1'b0;
    checkFrame("w2 BB", 8'hBB, -1);
    checkFrame("w2 DD", 8'hDD, -1);
    checkBit("w2 end busy", busy, 1'b0);
    checkBit("w2 end tx", tx, 1'b1);

    // All groups disabled.
    dataIn = 32'h1234_5678; dis = 4'b1111; send = 1'b1;
    tick;
    send = 1'b0;
    checkBit("empty busy N+1", busy, 1'b1);
    checkBit("empty tx N+1", tx, 1'b1);
    tick;
    checkBit("empty busy N+2", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkBit("empty tx idle", tx, 1'b1);
      tick;
    end
    checkBit("pre-overrun flag", overrun, 1'b0);

    // Overrun strobe 10 cycles in, then back-to-back send.
    dataIn = 32'h0000_00C3; dis = 4'b1110; send = 1'b1;
    tick;
    send = 1'b0;
    checkFrame("ovr C3", 8'hC3, 10);
    checkBit("ovr flag", overrun, 1'b1);
    checkBit("ovr busy low", busy, 1'b0);
    dataIn = 32'h0000_003C; dis = 4'b1110; send = 1'b1;
    tick;
    send = 1'b0;
    checkFrame("b2b 3C", 8'h3C, -1);
    checkBit("ovr sticky", overrun, 1'b1);
    checkBit("b2b end busy", busy, 1'b0);

    // Async reset during DATA bit 3 of 0x5A.
    dataIn = 32'h0000_005A; dis = 4'b1110; send = 1'b1;
    tick;
    send = 1'b0;
    repeat (4 * FAST_DIV + 1) tick;
    checkBit("5A bit3 tx", tx, 1'b1);
    checkBit("5A bit3 busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    checkBit("async rst tx", tx, 1'b1);
    checkBit("async rst busy", busy, 1'b0);
    checkBit("async rst overrun", overrun, 1'b0);
    tick;
    reset_n = 1'b1;
    tick;
    checkBit("post rst tx", tx, 1'b1);
    checkBit("post rst busy", busy, 1'b0);
    dataIn = 32'h0000_00A5; dis = 4'b1110; send = 1'b1;
    tick;
    send = 1'b0;
    checkFrame("A5", 8'hA5, -1);
    checkBit("A5 end busy", busy, 1'b0);

    // Full-rate divider, single byte 0x55.
    slowByte = 8'h55;
    sData = 32'h0000_0055; sDis = 4'b1110; sSend = 1'b1;
    tick;
    sSend = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < int'(SLOW_DIV); c++) begin
        if (i == 0) expBit = 1'b0;
        else if (i == 9) expBit = 1'b1;
        else expBit = slowByte[3'(i - 1)];
        checkBit($sformatf("slow tx bit%0d cyc%0d", i, c), sTx, expBit);
        checkBit($sformatf("slow busy bit%0d cyc%0d", i, c), sBusy, 1'b1);
        tick;
      end
    end
    checkBit("slow end busy", sBusy, 1'b0);
    checkBit("slow end tx", sTx, 1'b1);
    checkBit("slow overrun", sOverrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
- Downstream of the analyzer core: consumes the core's 32-bit memory read-back words, qualified by its send strobe, and returns the busy signal the core's controller throttles on.
- Serializes each word as up to four 8N1 UART bytes, LSB group first, and omits bytes belonging to disabled channel groups.
- Single clock domain (core clock); fixed-divider baud generation; single-word holding register.

Parameters:
- BAUD_DIV, 868, core clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clock  in  1  core clock; all logic on its rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- send  in  1  word strobe from the core (its outputSend); sampled only when busy=0.
- dataIn  in  32  word to transmit (the core's memoryWrData); captured in the same cycle as an accepted send.
- disabledGroups  in  4  bit g=1 suppresses byte g (dataIn[8g+7:8g]); captured with the word.
- busy  out  1  high while a word is held or being shifted; drives the core's outputBusy.
- tx  out  1  UART line, idle high, registered.
- overrun  out  1  sticky; set when send=1 while busy=1; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): tx=1, busy=0, overrun=0, state=IDLE, byte index=0, baud counter=0, shift register=0. Deassertion takes effect at the next clock edge.
- Accept: send=1 && busy=0 in cycle N captures dataIn and disabledGroups. busy=1 from N+1.
- States:
  - IDLE: waits for an accepted send, then goes to SEL.
  - SEL: picks the lowest g>=index with disabledGroups[g]=0 and loads byte g. If no such g remains, goes to IDLE with busy=0 next cycle. Otherwise goes to START.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each.
  - STOP: tx=1 for BAUD_DIV cycles, then index=g+1 and back to SEL.
- Timing:
  - SEL is folded combinationally into the IDLE->START and STOP->START transitions. For the first enabled byte, tx falls at N+1.
  - Consecutive bytes of one word are back to back with no idle cycles. Each byte takes exactly 10*BAUD_DIV cycles.
- Busy duration:
  - k enabled bytes: busy=1 for exactly k*10*BAUD_DIV cycles, starting at N+1.
  - busy falls in the same cycle the final STOP bit period ends.
  - A new send is accepted in the first cycle busy=0, so words can be back to back with at most 1 idle cycle between stop and start.
- All groups disabled (k=0): busy=1 for exactly one cycle (N+1). tx stays 1.
- Baud counter: loads BAUD_DIV-1 on entering each bit and decrements to 0; the bit ends at 0. No accumulated drift; every bit period is exactly BAUD_DIV cycles.
- send while busy=1: the strobe is ignored, the held word and the transmission are unaffected, and overrun becomes 1.
- Changes to dataIn or disabledGroups after capture have no effect until the next accepted send.
- Reset mid-byte: tx returns to 1 immediately (async). The partial frame is abandoned and not resumed.

Decomposition:
- Shared include: state encodings (IDLE, START, DATA, STOP), UART_FRAME_BITS=10, UART_DATA_BITS=8.
- One sub-module, uart_byte_tx (clock, reset_n, BAUD_DIV/CNT_W parameters): start/ld/byte in; tx, done out. It owns the baud counter and the START/DATA/STOP sequencing.
- The top level owns the word register, group-skip selection, busy and overrun.

Test Plan (BAUD_DIV=4 unless stated):
- Reset, then idle 100 cycles -> tx=1, busy=0, overrun=0 throughout.
- send with dataIn=0x44332211, disabledGroups=0000 -> tx carries bytes 0x11, 0x22, 0x33, 0x44, each 40 cycles, LSB first. busy high exactly 160 cycles from N+1.
- dataIn=0xDDCCBBAA, disabledGroups=0101 -> only 0xBB then 0xDD are sent; busy high exactly 80 cycles. Then disabledGroups=1111 -> busy high exactly 1 cycle, tx stays 1.
- send pulsed again 10 cycles into a transfer -> the first word completes unchanged and overrun=1 and stays 1. A send in the first busy=0 cycle is accepted, and tx falls on the next cycle.
- reset_n pulled low during the DATA bit 3 of 0x5A -> tx=1 and busy=0 within the same cycle (async). After release, a new send of 0x000000A5 with groups 1110 transmits 0xA5 correctly.
- BAUD_DIV=868, one byte 0x55 -> each bit period measures exactly 868 cycles and the frame exactly 8680 cycles.
